add_pipe: RTL and testbench



---
 rtl/add_pkg.sv | 34 +++
 rtl/add_pipe_stage.sv | 100 ++++++++++
 rtl/add_pipe.sv | 104 ++++++++++
 tb/tb_add_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// add_pkg: shared definitions for the pipelined adder/subtractor.
//   chunk_width()      - bits per carry-chain chunk, ceil(WIDTH/STAGES)
//   chunk_bits()       - actual width of chunk k (0 for chunks wholly beyond WIDTH)
//   last_chunk_width() - width of the final chunk (may be 0)
//   stage_ctl_t        - per-stage token control: valid flag and registered carry.
//                        The token's WIDTH-bit partial result and remaining a/b
//                        operands travel alongside it as plain vectors, because
//                        their width is a module parameter.
package add_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int chunk_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int chunk_bits(input int width, input int stages, input int idx);
    int cw;
    int lo;
    cw = chunk_width(width, stages);
    lo = idx * cw;
    if (lo >= width) return 0;
    if (width - lo < cw) return width - lo;
    return cw;
  endfunction

  function automatic int last_chunk_width(input int width, input int stages);
    return chunk_bits(width, stages, stages - 1);
  endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// add_pipe_stage: one carry-chain chunk plus its pipeline register.
// Adds bits [LO +: CW] of a_i/b_i with the incoming carry and writes the sum
// into the matching slice of the partial result. CW = 0 makes the stage an
// empty pass-through. KEEP_CARRY = 0 drops the carry register (used where the
// carry would only be the discarded MSB carry).
// Ports:
//   clock, reset      - clock, synchronous active-high reset
//   en_i              - global advance; 0 holds every register
//   ctl_i / ctl_o     - token valid and carry in / out
//   res_i / res_o     - partial result in / out
//   a_i, b_i / a_o, b_o - operands in / out (b already inverted for subtract)
module add_pipe_stage
  import add_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LO         = 0,
  parameter int CW         = 8,
  parameter int KEEP_CARRY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  stage_ctl_t       ctl_i,
  input  logic [WIDTH-1:0] res_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output stage_ctl_t       ctl_o,
  output logic [WIDTH-1:0] res_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  logic             valid_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_d;
  logic             carry_out;

  generate
    if (CW > 0) begin : g_add
      logic [CW:0] sum;
      always_comb begin
        sum = {1'b0, a_i[LO +: CW]} + {1'b0, b_i[LO +: CW]} + {{CW{1'b0}}, ctl_i.carry};
        res_d = res_i;
        res_d[LO +: CW] = sum[CW-1:0];
        carry_d = sum[CW];
      end
    end else begin : g_pass
      always_comb begin
        res_d   = res_i;
        carry_d = ctl_i.carry;
      end
    end
  endgenerate

  // Operands move whole; bits already consumed are never read by later stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (en_i) begin
      valid_q <= ctl_i.valid;
      res_q   <= res_d;
      a_q     <= a_i;
      b_q     <= b_i;
    end
  end

  generate
    if (KEEP_CARRY != 0) begin : g_carry
      logic carry_q;
      always_ff @(posedge clock) begin
        if (reset) begin
          carry_q <= 1'b0;
        end else if (en_i) begin
          carry_q <= carry_d;
        end
      end
      assign carry_out = carry_q;
    end else begin : g_no_carry
      logic unused_carry;
      assign unused_carry = carry_d;
      assign carry_out    = 1'b0;
    end
  endgenerate

  always_comb begin
    ctl_o.valid = valid_q;
    ctl_o.carry = carry_out;
  end

  assign res_o = res_q;
  assign a_o   = a_q;
  assign b_o   = b_q;

endmodule

// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit adder/subtractor, carry chain split into
// STAGES chunks, one chunk per pipeline stage. Result wraps modulo 2^WIDTH.
// Optional build macro: ADD_PIPE_CARRY_OUT_EN adds out_carry (carry out of the
// MSB for add, "no borrow" / a >= b for subtract).
// Ports:
//   clock, reset         - clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake
//   in_a, in_b, in_sub   - operands; in_sub=1 computes a-b
//   out_valid / out_ready - result handshake
//   out                  - result
//   out_carry            - (macro only) MSB carry / no-borrow flag
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef ADD_PIPE_CARRY_OUT_EN
  ,
  output logic             out_carry
`endif
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
`ifdef ADD_PIPE_CARRY_OUT_EN
  localparam int CARRY_EN = 1;
`else
  localparam int CARRY_EN = 0;
`endif

  // Index k is the input of stage k; index STAGES is the last stage's register.
  stage_ctl_t       ctl_c [0:STAGES];
  logic [WIDTH-1:0] res_c [0:STAGES];
  logic [WIDTH-1:0] a_c   [0:STAGES];
  logic [WIDTH-1:0] b_c   [0:STAGES];
  logic             advance;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The pipe stalls as a whole: it advances whenever the output slot is empty
  // or being taken, so a new operand and a finished result may move in the
  // same cycle. in_ready does not depend on in_valid.
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance && !reset;

  // Subtract is a + ~b + 1: invert b here and inject the +1 as stage-0 carry.
  assign ctl_c[0] = '{valid: in_valid, carry: in_sub};
  assign res_c[0] = '0;
  assign a_c[0]   = in_a;
  assign b_c[0]   = in_sub ? ~in_b : in_b;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * CHUNK;
      localparam int CW = chunk_bits(WIDTH, STAGES, k);
      // Carry out of a stage that ends at or beyond the MSB is the MSB carry,
      // needed only when it is exported.
      localparam int KEEP = (LO + CW < WIDTH) ? 1 : CARRY_EN;

      add_pipe_stage #(
        .WIDTH      (WIDTH),
        .LO         (LO),
        .CW         (CW),
        .KEEP_CARRY (KEEP)
      ) u_stage (
        .clock (clock),
        .reset (reset),
        .en_i  (advance),
        .ctl_i (ctl_c[k]),
        .res_i (res_c[k]),
        .a_i   (a_c[k]),
        .b_i   (b_c[k]),
        .ctl_o (ctl_c[k+1]),
        .res_o (res_c[k+1]),
        .a_o   (a_c[k+1]),
        .b_o   (b_c[k+1])
      );
    end
  endgenerate

  assign out_valid = ctl_c[STAGES].valid;
  assign out       = res_c[STAGES];

`ifdef ADD_PIPE_CARRY_OUT_EN
  assign out_carry = ctl_c[STAGES].carry;
`else
  logic unused_tail_carry;
  assign unused_tail_carry = ctl_c[STAGES].carry;
`endif

  // Operands leaving the last stage are fully consumed.
  logic unused_tail_ops;
  assign unused_tail_ops = ^{a_c[STAGES], b_c[STAGES]};

endmodule

// File: tb/tb_add_pipe.sv
module tb_add_pipe;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int W7 = 7;
  localparam int S7 = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // 8-bit, 2-stage instance
  logic         in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out;
  logic         out_carry;

  // 7-bit, 3-stage instance
  logic          in7_valid, in7_ready, in7_sub, out7_valid, out7_ready;
  logic [W7-1:0] in7_a, in7_b, out7;
  logic          out7_carry;

  add_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef ADD_PIPE_CARRY_OUT_EN
    ,
    .out_carry (out_carry)
`endif
  );

  add_pipe #(.WIDTH(W7), .STAGES(S7)) dut7 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in7_valid),
    .in_ready  (in7_ready),
    .in_a      (in7_a),
    .in_b      (in7_b),
    .in_sub    (in7_sub),
    .out_valid (out7_valid),
    .out_ready (out7_ready),
    .out       (out7)
`ifdef ADD_PIPE_CARRY_OUT_EN
    ,
    .out_carry (out7_carry)
`endif
  );

`ifndef ADD_PIPE_CARRY_OUT_EN
  assign out_carry  = 1'b0;
  assign out7_carry = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0]    exp_q[$];   // {carry, result}
  logic [W7:0]   exp7_q[$];

  // Reference: plain modular arithmetic on integers.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    longint unsigned m, ua, ub, s;
    logic c;
    m  = 64'd1 << W;
    ua = a;
    ub = b;
    if (sub) begin
      s = (ua + m - ub) % m;
      c = (ua >= ub);
    end else begin
      s = (ua + ub) % m;
      c = ((ua + ub) >= m);
    end
    return {c, s[W-1:0]};
  endfunction

  function automatic logic [W7:0] model7(input logic [W7-1:0] a, input logic [W7-1:0] b,
                                         input logic sub);
    longint unsigned m, ua, ub, s;
    logic c;
    m  = 64'd1 << W7;
    ua = a;
    ub = b;
    if (sub) begin
      s = (ua + m - ub) % m;
      c = (ua >= ub);
    end else begin
      s = (ua + ub) % m;
      c = ((ua + ub) >= m);
    end
    return {c, s[W7-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitors: every completed result must match the head of the queue.
  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", exp_q.size(), 1);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("out_data", out, e[W-1:0]);
`ifdef ADD_PIPE_CARRY_OUT_EN
        check("out_carry", out_carry, e[W]);
`endif
      end
    end
  end

  always @(negedge clock) begin
    if (out7_valid && out7_ready) begin
      if (exp7_q.size() == 0) begin
        check("spurious_out7", exp7_q.size(), 1);
      end else begin
        logic [W7:0] e;
        e = exp7_q.pop_front();
        check("out7_data", out7, e[W7-1:0]);
`ifdef ADD_PIPE_CARRY_OUT_EN
        check("out7_carry", out7_carry, e[W7]);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one operand pair, wait (bounded) for in_ready, let it be accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    #1;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard == 50) check("send_timeout", in_ready, 1);
    exp_q.push_back(model(a, b, sub));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || exp7_q.size() != 0) && guard < 100) begin
      step();
      guard++;
    end
    check(tag, exp_q.size() + exp7_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] held;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_sub     = 1'b0;
    out_ready  = 1'b1;
    in7_valid  = 1'b0;
    in7_a      = '0;
    in7_b      = '0;
    in7_sub    = 1'b0;
    out7_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_out7_valid", out7_valid, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Inter-chunk carry and exact latency
    send(8'h0F, 8'h01, 1'b0);
    check("lat_early", out_valid, 0);
    step();
    check("lat_valid", out_valid, 1);
    check("chunk_carry", out, 8'h10);
    step();

    // Wrap-around and subtract
    send(8'hFF, 8'h01, 1'b0);
    step();
    check("wrap_out", out, 8'h00);
`ifdef ADD_PIPE_CARRY_OUT_EN
    check("wrap_carry", out_carry, 1);
`endif
    send(8'h05, 8'h07, 1'b1);
    step();
    check("sub_out", out, 8'hFE);
`ifdef ADD_PIPE_CARRY_OUT_EN
    check("sub_carry", out_carry, 0);
`endif
    drain("directed_drain");

    // Back-to-back burst of 16 random pairs
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_sub   = 1'($urandom_range(0, 1));
      #1;
      check("burst_in_ready", in_ready, 1);
      exp_q.push_back(model(in_a, in_b, in_sub));
      step();
      if (i >= 1) check("burst_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    check("burst_last_valid", out_valid, 1);
    step();
    check("burst_end_valid", out_valid, 0);
    check("burst_drained", exp_q.size(), 0);

    // Stall with a full pipe
    out_ready = 1'b0;
    send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    in_valid = 1'b1;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_sub   = 1'($urandom_range(0, 1));
    #1;
    check("full_in_ready", in_ready, 0);
    held = out;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_stable", out, held);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    exp_q.push_back(model(in_a, in_b, in_sub));
    step();
    in_valid = 1'b0;
    drain("stall_drain");

    // 7-bit, 3-stage: chunks 3,3,1
    in7_valid = 1'b1;
    in7_a     = 7'h7F;
    in7_b     = 7'h01;
    in7_sub   = 1'b0;
    #1;
    check("w7_in_ready", in7_ready, 1);
    exp7_q.push_back(model7(in7_a, in7_b, in7_sub));
    step();
    in7_valid = 1'b0;
    check("w7_early1", out7_valid, 0);
    step();
    check("w7_early2", out7_valid, 0);
    step();
    check("w7_valid", out7_valid, 1);
    check("w7_wrap", out7, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      in7_valid = 1'b1;
      in7_a     = W7'($urandom);
      in7_b     = W7'($urandom);
      in7_sub   = 1'($urandom_range(0, 1));
      exp7_q.push_back(model7(in7_a, in7_b, in7_sub));
      step();
    end
    in7_valid = 1'b0;
    drain("w7_drain");

    // Reset with two tokens in flight
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    send(8'h56, 8'h78, 1'b1);
    check("inflight_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    step();
    reset = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    #1;
    check("after_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("rst_flush_valid", out_valid, 0);
      step();
    end
    send(8'h9A, 8'h0B, 1'b0);
    step();
    check("post_rst_sum", out, 8'hA5);
    drain("post_rst_drain");

    // Random traffic with random back-pressure
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("random_drain");

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
